// File: rtl/wall_sprite_arbiter.sv
// Two-requester round-robin front end for the sprite frame RAM.
// Grants are combinational; responses return in grant order with a fixed latency of 2.
module wall_sprite_arbiter #(
  parameter int DEPTH  = 2112,
  parameter int ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [18:0]       ram_addr,
  input  logic [4:0]        ram_data,
  output logic [1:0]        rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              oor_err
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef struct packed {
    logic valid;
    logic id;
    logic oor;
  } tag_t;

  logic              ptr_reg, ptr_next;
  logic [18:0]       ram_addr_reg, ram_addr_next;
  logic              oor_reg, oor_next;
  tag_t              tag1_reg, tag2_reg, grant_tag;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oor;
  logic              unused_ram_bits;

  // Only the palette index bits of the RAM word are used.
  assign unused_ram_bits = ^ram_data[4:2];

  // ptr_reg names the requester that wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Reset) begin
      if (req0 && req1) begin
        gnt0 = ~ptr_reg;
        gnt1 = ptr_reg;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    grant_any     = gnt0 | gnt1;
    sel_addr      = gnt1 ? addr1 : addr0;
    sel_oor       = (32'(sel_addr) >= DEPTH_U);
    ptr_next      = grant_any ? gnt0 : ptr_reg;
    ram_addr_next = ram_addr_reg;
    if (grant_any) begin
      ram_addr_next = sel_oor ? 19'd0 : 19'(sel_addr);
    end
    oor_next      = oor_reg | (grant_any & sel_oor);
    grant_tag     = '{valid: grant_any, id: gnt1, oor: sel_oor};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_reg      <= 1'b0;
      ram_addr_reg <= 19'd0;
      oor_reg      <= 1'b0;
      tag1_reg     <= '0;
      tag2_reg     <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      ram_addr_reg <= ram_addr_next;
      oor_reg      <= oor_next;
      tag1_reg     <= grant_tag;
      tag2_reg     <= tag1_reg;
    end
  end

  // Stage 2 lines up with the RAM's registered data_Out.
  always_comb begin
    ram_addr = ram_addr_reg;
    oor_err  = oor_reg;
    rvalid0  = tag2_reg.valid & ~tag2_reg.id;
    rvalid1  = tag2_reg.valid & tag2_reg.id;
    rdata    = (tag2_reg.valid && !tag2_reg.oor) ? ram_data[1:0] : 2'b00;
  end

endmodule

// File: tb/tb_wall_sprite_arbiter.sv
// Bench for wall_sprite_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based behavioural model.
module tb_wall_sprite_arbiter;
  localparam int DEPTH  = 2112;
  localparam int ADDR_W = 12;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1;
  logic [18:0]       ram_addr;
  logic [4:0]        ram_data;
  logic [1:0]        rdata;
  logic              rvalid0, rvalid1;
  logic              oor_err;

  always #5 Clk = ~Clk;

  wall_sprite_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .oor_err(oor_err)
  );

  // Sprite frame RAM with a one-cycle registered read.
  logic [4:0] mem [0:4095];
  always @(posedge Clk) ram_data <= mem[ram_addr[11:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending responses with the cycle they are due in.
  typedef struct {
    int       due;
    bit       id;
    bit [1:0] data;
  } resp_t;

  resp_t       q[$];
  bit          m_ptr      = 1'b0;
  logic [18:0] m_ram_addr = '0;
  bit          m_oor      = 1'b0;
  int          cyc        = 0;
  bit          checking   = 1'b0;
  int          wait0      = 0;
  int          wait1      = 0;
  bit          last_g0    = 1'b0;
  bit          last_g1    = 1'b0;

  always @(negedge Clk) begin : model
    bit e_g0, e_g1, e_v0, e_v1, oor;
    bit [1:0] e_d;
    logic [ADDR_W-1:0] a;
    resp_t r;
    if (checking) begin
      e_g0 = !Reset && req0 && (!req1 || !m_ptr);
      e_g1 = !Reset && req1 && (!req0 || m_ptr);
      check("gnt0", gnt0, e_g0);
      check("gnt1", gnt1, e_g1);
      e_v0 = 1'b0;
      e_v1 = 1'b0;
      e_d  = 2'b00;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_v0 = !q[0].id;
        e_v1 = q[0].id;
        e_d  = q[0].data;
        void'(q.pop_front());
      end
      check("rvalid0", rvalid0, e_v0);
      check("rvalid1", rvalid1, e_v1);
      check("rdata", rdata, e_d);
      check("ram_addr", ram_addr, m_ram_addr);
      check("oor_err", oor_err, m_oor);
      if (gnt0) check("wait_bound0", wait0 <= 1, 1);
      if (gnt1) check("wait_bound1", wait1 <= 1, 1);
      if (Reset) begin
        m_ptr      = 1'b0;
        q.delete();
        m_ram_addr = '0;
        m_oor      = 1'b0;
        wait0      = 0;
        wait1      = 0;
      end else begin
        wait0 = (req0 && !gnt0) ? wait0 + 1 : 0;
        wait1 = (req1 && !gnt1) ? wait1 + 1 : 0;
        if (e_g0 || e_g1) begin
          a          = e_g1 ? addr1 : addr0;
          oor        = (int'(a) >= DEPTH);
          r.due      = cyc + 2;
          r.id       = e_g1;
          r.data     = oor ? 2'b00 : mem[a][1:0];
          q.push_back(r);
          m_ram_addr = oor ? 19'd0 : 19'(a);
          m_oor      = m_oor | oor;
          m_ptr      = e_g0;
        end
      end
    end
    last_g0 = gnt0;
    last_g1 = gnt1;
    cyc++;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 12'(2108 + $urandom_range(0, 7));
      1:       return 12'($urandom_range(0, 4095));
      default: return 12'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    int first_g1, nresp;
    bit g0, g1;
    for (int i = 0; i < 4096; i++) mem[i] = 5'($urandom);
    mem[5]    = 5'b10111;
    mem[10]   = 5'b00101;
    mem[20]   = 5'b11110;
    mem[2111] = 5'b01110;
    Reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    step();
    checking = 1'b1;
    @(negedge Clk);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_oor_err", oor_err, 0);
    check("rst_gnt", {gnt0, gnt1}, 0);
    step();
    Reset = 1'b0;

    // Single request, fixed latency 2.
    req0 = 1'b1; addr0 = 12'd5;
    @(negedge Clk);
    check("t1_gnt0", gnt0, 1);
    check("t1_gnt1", gnt1, 0);
    step(); req0 = 1'b0;
    @(negedge Clk);
    check("t1_ram_addr", ram_addr, 5);
    check("t1_early_rvalid", rvalid0, 0);
    step();
    @(negedge Clk);
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata", rdata, 2'b11);
    step();

    // Both requesting: alternation starting with requester 0.
    do_reset();
    addr0 = 12'd10; addr1 = 12'd20;
    for (int i = 0; i < 6; i++) begin
      req0 = (i < 4); req1 = (i < 4);
      @(negedge Clk);
      if (i < 4) begin
        check("t2_gnt0", gnt0, (i % 2) == 0);
        check("t2_gnt1", gnt1, (i % 2) == 1);
      end
      if (i >= 2) begin
        check("t2_rvalid0", rvalid0, (i % 2) == 0);
        check("t2_rvalid1", rvalid1, (i % 2) == 1);
        check("t2_rdata", rdata, ((i % 2) == 0) ? 2'b01 : 2'b10);
      end
      step();
    end

    // Last valid word, then first out-of-range word.
    req1 = 1'b1; addr1 = 12'd2111;
    @(negedge Clk);
    check("t3_gnt1_a", gnt1, 1);
    step(); addr1 = 12'd2112;
    @(negedge Clk);
    check("t3_gnt1_b", gnt1, 1);
    check("t3_ram_addr_a", ram_addr, 2111);
    step(); req1 = 1'b0;
    @(negedge Clk);
    check("t3_ram_addr_b", ram_addr, 0);
    check("t3_rvalid1_a", rvalid1, 1);
    check("t3_rdata_a", rdata, 2'b10);
    check("t3_oor_a", oor_err, 1);
    step();
    @(negedge Clk);
    check("t3_rvalid1_b", rvalid1, 1);
    check("t3_rdata_b", rdata, 2'b00);
    check("t3_oor_b", oor_err, 1);
    step(); req0 = 1'b1; addr0 = 12'd5;
    @(negedge Clk);
    check("t3_gnt0", gnt0, 1);
    step(); req0 = 1'b0;
    step();
    @(negedge Clk);
    check("t3_rvalid0", rvalid0, 1);
    check("t3_rdata_c", rdata, 2'b11);
    check("t3_oor_sticky", oor_err, 1);
    step();

    // Reset one cycle after a grant discards it.
    req0 = 1'b1; addr0 = 12'd7;
    @(negedge Clk);
    check("t4_gnt0", gnt0, 1);
    step(); req0 = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    check("t4_gnt_in_reset", {gnt0, gnt1}, 0);
    step(); Reset = 1'b0;
    @(negedge Clk);
    check("t4_rvalid_a", {rvalid0, rvalid1}, 0);
    check("t4_ram_addr", ram_addr, 0);
    check("t4_oor", oor_err, 0);
    step(); req0 = 1'b1; req1 = 1'b1; addr0 = 12'd30; addr1 = 12'd31;
    @(negedge Clk);
    check("t4_rvalid_b", {rvalid0, rvalid1}, 0);
    check("t4_ptr_gnt0", gnt0, 1);
    step(); req0 = 1'b0;
    @(negedge Clk);
    check("t4_gnt1", gnt1, 1);
    step(); req1 = 1'b0;
    step(); step();

    // Requester 0 streaming, requester 1 joins at cycle 3.
    do_reset();
    addr0 = 12'd100;
    first_g1 = -1;
    nresp = 0;
    for (int i = 0; i < 10; i++) begin
      req0 = (i < 8);
      if (i == 3) begin
        req1 = 1'b1; addr1 = 12'd200;
      end
      @(negedge Clk);
      g0 = gnt0; g1 = gnt1;
      if (g1 && first_g1 < 0) first_g1 = i;
      nresp += int'(rvalid0) + int'(rvalid1);
      step();
      if (g0) addr0 = addr0 + 12'd1;
      if (g1) req1 = 1'b0;
    end
    check("t5_gnt1_by_4", (first_g1 >= 3) && (first_g1 <= 4), 1);
    check("t5_responses", nresp, 8);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 99) == 0);
      if (last_g0) req0 = 1'b0;
      if (last_g1) req1 = 1'b0;
      if (!req0 && $urandom_range(0, 3) != 0) begin
        req0 = 1'b1; addr0 = rand_addr();
      end
      if (!req1 && $urandom_range(0, 3) != 0) begin
        req1 = 1'b1; addr1 = rand_addr();
      end
      step();
    end
    Reset = 1'b0;
    if (last_g0) req0 = 1'b0;
    if (last_g1) req1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (last_g0) req0 = 1'b0;
      if (last_g1) req1 = 1'b0;
    end
    step();
    check("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wall_sprite_arbiter.md
WALL_SPRITE_ARBITER -- requirements
Module: wall_sprite_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2112, meaning number of valid sprite-RAM words.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning width of requester word addresses.
REQ-003 SHALL have port Clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req0 / req1  input  1 each  read request from requester 0 / 1, held high until granted.
REQ-006 SHALL have port addr0 / addr1  input  ADDR_W each  word address for requester 0 / 1, stable while its req is high.
REQ-007 SHALL have port gnt0 / gnt1  output  1 each  combinational grant; request accepted in the cycle it is high.
REQ-008 SHALL have port ram_addr  output  19  registered read address to the sprite frame RAM read port.
REQ-009 SHALL have port ram_data  input  5  sprite frame RAM data_Out; only bits [1:0] are meaningful.
REQ-010 SHALL have port rdata  output  2  returned palette index.
REQ-011 SHALL have port rvalid0 / rvalid1  output  1 each  one-cycle strobe: rdata belongs to requester 0 / 1.
REQ-012 SHALL have port oor_err  output  1  sticky flag: an out-of-range address was accepted.

Function
REQ-013 SHALL assert at most one of gnt0/gnt1 per cycle, and only for a requester whose req is high.
REQ-014 SHALL grant the sole requester when exactly one req is high, regardless of priority pointer.
REQ-015 SHALL, when both req are high, grant the requester named by a 1-bit round-robin pointer.
REQ-016 SHALL set the pointer to the non-granted requester at the end of every cycle with a grant; no grant leaves it unchanged.
REQ-017 SHALL guarantee a continuously requesting requester is granted within 2 cycles (no starvation).
REQ-018 SHALL sustain one accepted request per cycle (back-to-back grants, no bubbles).
REQ-019 SHALL, on grant in cycle N, register the granted address zero-extended into ram_addr, valid during cycle N+1.
REQ-020 SHALL treat a granted address >= DEPTH as out-of-range: ram_addr loads 0, request still completes, oor_err sets to 1.
REQ-021 SHALL hold ram_addr at its previous value in cycles with no grant.
REQ-022 SHALL carry a 2-stage tag pipeline (valid, requester id, out-of-range bit) aligned to the RAM's one-cycle registered read.
REQ-023 SHALL assert exactly one rvalid strobe, for the granted requester, during cycle N+2 (fixed latency 2).
REQ-024 SHALL drive rdata = ram_data[1:0] when the stage-2 tag is valid and in-range, and 2'b00 (transparent) when it is out-of-range.
REQ-025 SHALL drive rdata = 2'b00 whenever neither rvalid is high.
REQ-026 SHALL return responses in grant order; requester ids never reorder.
REQ-027 SHALL keep oor_err high until Reset; a later in-range access does not clear it.

Reset
REQ-028 SHALL, while Reset is high at a rising edge, clear ram_addr to 0, both tag stages to invalid, the pointer to 0 (requester 0 favoured), and oor_err to 0.
REQ-029 SHALL force gnt0 = gnt1 = 0 during any cycle Reset is high; requests are not accepted.
REQ-030 SHALL discard in-flight requests on reset mid-operation: no rvalid in the 2 cycles after Reset deasserts unless newly granted.

Verification
REQ-031 Bench SHALL cover: only req0, addr0=5, RAM word 5 = 2'b11 -> gnt0 in cycle N, ram_addr=5 in N+1, rvalid0=1 and rdata=2'b11 in N+2.
REQ-032 Bench SHALL cover: req0 and req1 held high 4 cycles after reset -> grants 0,1,0,1; rvalid pattern 0,1,0,1 starting 2 cycles later.
REQ-033 Bench SHALL cover: req1 alone at addr 2111, then addr 2112 -> first returns RAM[2111], second ram_addr=0, rdata=2'b00, oor_err=1 and stays 1.
REQ-034 Bench SHALL cover: Reset asserted one cycle after a grant -> no rvalid observed, ram_addr=0, pointer=0, oor_err=0.
REQ-035 Bench SHALL cover: req0 continuous for 8 cycles with req1 idle, req1 raised at cycle 3 -> gnt1 no later than cycle 4, every accepted request returns exactly once, in order.
